// File: rtl/regalu_ctrl_if.sv
// Instruction-word handshake between an upstream producer and regalu_ctrl.
// master = producer side, slave = regalu_ctrl side.
interface regalu_ctrl_if;
   logic        instr_valid;
   logic [31:0] instr_in;
   logic        instr_ready;

   modport master (output instr_valid, output instr_in, input instr_ready);
   modport slave  (input instr_valid, input instr_in, output instr_ready);
endinterface

// File: rtl/regalu_ctrl.sv
// regalu_ctrl: instruction sequencer driving the register-file/ALU datapath.
// Buffers instruction words in a DEPTH-entry FIFO and issues one decoded word
// per cycle as registered control outputs; supports carry-conditional skip
// (SKC) and HALT/resume.
// Optional build macro: REGALU_CTRL_STATS_EN adds issue_count/skip_count.
module regalu_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic        clk,
   input  logic        reset,
   regalu_ctrl_if.slave instr_if,
   input  logic        resume,
   input  logic        cout,
   output logic        sel,
   output logic        wr,
   output logic [1:0]  op,
   output logic [2:0]  rd_addr_a,
   output logic [2:0]  rd_addr_b,
   output logic [2:0]  wr_addr,
   output logic [15:0] d_in,
   output logic        carry_flag,
   output logic        halted,
   output logic        busy
`ifdef REGALU_CTRL_STATS_EN
   ,
   output logic [15:0] issue_count,
   output logic [15:0] skip_count
`endif
);

   localparam int unsigned IW = 32;
   localparam int unsigned DW = 16;
   localparam int unsigned PW = AW + 1;

   localparam logic [2:0] OPC_LDI  = 3'b001;
   localparam logic [2:0] OPC_ALU  = 3'b010;
   localparam logic [2:0] OPC_RD   = 3'b011;
   localparam logic [2:0] OPC_SKC  = 3'b100;
   localparam logic [2:0] OPC_HALT = 3'b101;

   typedef struct packed {
      logic          sel;
      logic          wr;
      logic [1:0]    op;
      logic [2:0]    rd_a;
      logic [2:0]    rd_b;
      logic [2:0]    wr_addr;
      logic [DW-1:0] d_in;
   } ctrl_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t        state_q, state_d;
   ctrl_t         ctrl_q, ctrl_d;
   logic          carry_q, carry_d;
   logic          skip_q, skip_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [IW-1:0] mem_q [DEPTH];

   logic          full, empty, push, pop;
   logic [IW-1:0] head;
   logic [2:0]    f_opc;
   logic [1:0]    f_op;
   logic [2:0]    f_rd_a, f_rd_b, f_wr_addr;
   logic [DW-1:0] f_imm;
   logic          unused_rsvd;

   // FIFO status; the extra pointer MSB separates full from empty
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push  = instr_if.instr_valid && !full;
   assign instr_if.instr_ready = !full;

   // Head-of-FIFO field extraction; bits [17:16] are reserved and ignored
   assign head        = mem_q[rd_ptr_q[AW-1:0]];
   assign f_opc       = head[31:29];
   assign f_op        = head[28:27];
   assign f_rd_a      = head[26:24];
   assign f_rd_b      = head[23:21];
   assign f_wr_addr   = head[20:18];
   assign f_imm       = head[15:0];
   assign unused_rsvd = ^head[17:16];

   // FIFO storage; no reset needed since pointers qualify every read
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= instr_if.instr_in;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_RUN;
         ctrl_q   <= '0;
         carry_q  <= 1'b0;
         skip_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         carry_q  <= carry_d;
         skip_q   <= skip_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Next state: pop/decode, carry capture, skip and halt handling
   always_comb begin
      state_d = state_q;
      ctrl_d  = '0;
      carry_d = carry_q;
      skip_d  = skip_q;
      pop     = 1'b0;

      // Carry is sampled while an ALU write is on the outputs
      if (ctrl_q.sel && ctrl_q.wr) begin
         carry_d = cout;
      end

      unique case (state_q)
         ST_RUN: begin
            if (!empty) begin
               pop = 1'b1;
               if (skip_q) begin
                  skip_d = 1'b0;
               end else begin
                  unique case (f_opc)
                     OPC_LDI: begin
                        ctrl_d.wr      = 1'b1;
                        ctrl_d.wr_addr = f_wr_addr;
                        ctrl_d.d_in    = f_imm;
                     end
                     OPC_ALU: begin
                        ctrl_d.sel     = 1'b1;
                        ctrl_d.wr      = 1'b1;
                        ctrl_d.op      = f_op;
                        ctrl_d.rd_a    = f_rd_a;
                        ctrl_d.rd_b    = f_rd_b;
                        ctrl_d.wr_addr = f_wr_addr;
                     end
                     OPC_RD: begin
                        ctrl_d.rd_a = f_rd_a;
                        ctrl_d.rd_b = f_rd_b;
                     end
                     // Uses the carry as updated on this same edge
                     OPC_SKC:  skip_d  = carry_d;
                     OPC_HALT: state_d = ST_HALTED;
                     default: ;
                  endcase
               end
            end
         end
         ST_HALTED: begin
            if (resume) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase

      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
   end

   assign sel        = ctrl_q.sel;
   assign wr         = ctrl_q.wr;
   assign op         = ctrl_q.op;
   assign rd_addr_a  = ctrl_q.rd_a;
   assign rd_addr_b  = ctrl_q.rd_b;
   assign wr_addr    = ctrl_q.wr_addr;
   assign d_in       = ctrl_q.d_in;
   assign carry_flag = carry_q;
   assign halted     = (state_q == ST_HALTED);
   assign busy       = !empty || skip_q;

`ifdef REGALU_CTRL_STATS_EN
   logic [15:0] issue_cnt_q, skip_cnt_q;

   // Issued vs discarded pop counters, free-running with wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issue_cnt_q <= '0;
         skip_cnt_q  <= '0;
      end else begin
         if (pop && !skip_q) begin
            issue_cnt_q <= issue_cnt_q + 16'd1;
         end
         if (pop && skip_q) begin
            skip_cnt_q <= skip_cnt_q + 16'd1;
         end
      end
   end

   assign issue_count = issue_cnt_q;
   assign skip_count  = skip_cnt_q;
`endif

endmodule

// File: tb/tb_regalu_ctrl.sv
// Testbench for regalu_ctrl: decode vector table, scoreboard of issued words,
// and hand sequences for skip, halt/resume, FIFO full and mid-run reset.
module tb_regalu_ctrl;

   typedef struct packed {
      logic        sel;
      logic        wr;
      logic [1:0]  op;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [2:0]  wa;
      logic [15:0] d;
   } out_t;

   typedef struct {
      logic [31:0] instr;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        resume;
   logic        cout;
   logic        sel, wr;
   logic [1:0]  op;
   logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
   logic [15:0] d_in;
   logic        carry_flag, halted, busy;
`ifdef REGALU_CTRL_STATS_EN
   logic [15:0] issue_count, skip_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   out_t exp_q[$];

   regalu_ctrl_if bus();

   regalu_ctrl #(.DEPTH(4), .AW(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .instr_if   (bus),
      .resume     (resume),
      .cout       (cout),
      .sel        (sel),
      .wr         (wr),
      .op         (op),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .wr_addr    (wr_addr),
      .d_in       (d_in),
      .carry_flag (carry_flag),
      .halted     (halted),
      .busy       (busy)
`ifdef REGALU_CTRL_STATS_EN
      ,
      .issue_count(issue_count),
      .skip_count (skip_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk(input logic [2:0] opc, input logic [1:0] o,
                                      input logic [2:0] ra, input logic [2:0] rb,
                                      input logic [2:0] wa, input logic [15:0] imm);
      mk = {opc, o, ra, rb, wa, 2'b00, imm};
   endfunction

   function automatic out_t mko(input logic s, input logic w, input logic [1:0] o,
                                input logic [2:0] ra, input logic [2:0] rb,
                                input logic [2:0] wa, input logic [15:0] d);
      mko = {s, w, o, ra, rb, wa, d};
   endfunction

   function automatic out_t cur();
      cur = {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word until accepted (bounded); queue its visible issue pattern
   task automatic push_word(input logic [31:0] w, input logic vis, input out_t e);
      logic acc;
      acc = 1'b0;
      bus.instr_valid = 1'b1;
      bus.instr_in    = w;
      for (int k = 0; k < 50 && !acc; k++) begin
         acc = bus.instr_ready;
         tick();
      end
      bus.instr_valid = 1'b0;
      if (!acc) check("push_timeout", 32'd0, 32'd1);
      else if (vis) exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      bus.instr_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Scoreboard: every non-NOP output pattern must match the next expected issue
   always @(negedge clk) begin
      out_t a;
      a = cur();
      if (a != '0) begin
         if (exp_q.size() == 0) check("spurious_issue", 32'(a), 32'd0);
         else check("issue_order", 32'(a), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      vec_t  vecs[7];
      out_t  hw[4];
      int    n_acc;
      logic  acc;
      logic [15:0] ic0, sc0;

      vecs[0] = '{mk(3'd0, 2'd3, 3'd7, 3'd7, 3'd7, 16'hffff), mko(0, 0, 0, 0, 0, 0, 16'h0)};
      vecs[1] = '{mk(3'd1, 2'd2, 3'd5, 3'd6, 3'd4, 16'ha5a5), mko(0, 1, 0, 0, 0, 4, 16'ha5a5)};
      vecs[2] = '{mk(3'd2, 2'd3, 3'd1, 3'd6, 3'd2, 16'hffff), mko(1, 1, 3, 1, 6, 2, 16'h0)};
      vecs[3] = '{mk(3'd3, 2'd1, 3'd7, 3'd2, 3'd5, 16'h1234), mko(0, 0, 0, 7, 2, 0, 16'h0)};
      vecs[4] = '{mk(3'd4, 2'd1, 3'd3, 3'd3, 3'd3, 16'h5555), mko(0, 0, 0, 0, 0, 0, 16'h0)};
      vecs[5] = '{mk(3'd6, 2'd2, 3'd2, 3'd4, 3'd6, 16'h0f0f), mko(0, 0, 0, 0, 0, 0, 16'h0)};
      vecs[6] = '{32'hffff_ffff,                              mko(0, 0, 0, 0, 0, 0, 16'h0)};

      reset = 1'b1; resume = 1'b0; cout = 1'b0;
      bus.instr_valid = 1'b0; bus.instr_in = '0;
      repeat (2) tick();
      check("rst_outputs", 32'(cur()), 32'd0);
      check("rst_ready",   32'(bus.instr_ready), 32'd1);
      check("rst_busy",    32'(busy), 32'd0);
      check("rst_halted",  32'(halted), 32'd0);
      check("rst_carry",   32'(carry_flag), 32'd0);
      reset = 1'b0;
      tick();

      // Decode table, one word at a time with cout held low
      for (int i = 0; i < 7; i++) begin
         push_word(vecs[i].instr, vecs[i].exp != '0, vecs[i].exp);
         tick();
         check($sformatf("vec%0d_out", i), 32'(cur()), 32'(vecs[i].exp));
         check($sformatf("vec%0d_halted", i), 32'(halted), 32'd0);
         idle(2);
      end

      // Back-to-back LDI, LDI, ALU on consecutive cycles
      push_word(mk(3'd1, 2'd0, 3'd0, 3'd0, 3'd3, 16'hcdef), 1'b1, mko(0, 1, 0, 0, 0, 3, 16'hcdef));
      push_word(mk(3'd1, 2'd0, 3'd0, 3'd0, 3'd7, 16'h3210), 1'b1, mko(0, 1, 0, 0, 0, 7, 16'h3210));
      check("b2b_ldi3", 32'(cur()), 32'(mko(0, 1, 0, 0, 0, 3, 16'hcdef)));
      push_word(mk(3'd2, 2'd0, 3'd3, 3'd7, 3'd5, 16'h0000), 1'b1, mko(1, 1, 0, 3, 7, 5, 16'h0));
      check("b2b_ldi7", 32'(cur()), 32'(mko(0, 1, 0, 0, 0, 7, 16'h3210)));
      tick();
      check("b2b_alu", 32'(cur()), 32'(mko(1, 1, 0, 3, 7, 5, 16'h0)));
      idle(3);

      // ALU with carry out, SKC, LDI r1 (skipped), LDI r2
`ifdef REGALU_CTRL_STATS_EN
      ic0 = issue_count; sc0 = skip_count;
`else
      ic0 = '0; sc0 = '0;
`endif
      cout = 1'b1;
      push_word(mk(3'd2, 2'd1, 3'd1, 3'd2, 3'd4, 16'h0000), 1'b1, mko(1, 1, 1, 1, 2, 4, 16'h0));
      push_word(mk(3'd4, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000), 1'b0, '0);
      push_word(mk(3'd1, 2'd0, 3'd0, 3'd0, 3'd1, 16'h1111), 1'b0, '0);
      push_word(mk(3'd1, 2'd0, 3'd0, 3'd0, 3'd2, 16'h2222), 1'b1, mko(0, 1, 0, 0, 0, 2, 16'h2222));
      idle(4);
      check("skc1_carry", 32'(carry_flag), 32'd1);
      check("skc1_busy",  32'(busy), 32'd0);
`ifdef REGALU_CTRL_STATS_EN
      check("skc1_skip_count",  32'(16'(skip_count - sc0)), 32'd1);
      check("skc1_issue_count", 32'(16'(issue_count - ic0)), 32'd3);
`endif
      cout = 1'b0;

      // Same sequence with no carry: both loads issue
      push_word(mk(3'd2, 2'd1, 3'd1, 3'd2, 3'd4, 16'h0000), 1'b1, mko(1, 1, 1, 1, 2, 4, 16'h0));
      push_word(mk(3'd4, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000), 1'b0, '0);
      push_word(mk(3'd1, 2'd0, 3'd0, 3'd0, 3'd1, 16'h1111), 1'b1, mko(0, 1, 0, 0, 0, 1, 16'h1111));
      push_word(mk(3'd1, 2'd0, 3'd0, 3'd0, 3'd2, 16'h2222), 1'b1, mko(0, 1, 0, 0, 0, 2, 16'h2222));
      idle(4);
      check("skc0_carry", 32'(carry_flag), 32'd0);
      check("skc0_drain", 32'(exp_q.size()), 32'd0);

      // HALT, then offer 6 words: only 4 fit
      push_word(mk(3'd5, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000), 1'b0, '0);
      idle(3);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_out",  32'(cur()), 32'd0);
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         bus.instr_valid = 1'b1;
         bus.instr_in    = mk(3'd1, 2'd0, 3'd0, 3'd0, 3'(i), 16'h4000 + 16'(i));
         acc = bus.instr_ready;
         tick();
         if (acc) begin
            hw[n_acc] = mko(0, 1, 0, 0, 0, 3'(i), 16'h4000 + 16'(i));
            exp_q.push_back(hw[n_acc]);
            n_acc++;
         end
      end
      bus.instr_valid = 1'b0;
      check("full_accepts", 32'(n_acc), 32'd4);
      check("full_ready",   32'(bus.instr_ready), 32'd0);
      check("full_halted",  32'(halted), 32'd1);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      check("resume_halted", 32'(halted), 32'd0);
      check("resume_out",    32'(cur()), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("resume_issue%0d", i), 32'(cur()), 32'(hw[i]));
      end
      check("resume_ready", 32'(bus.instr_ready), 32'd1);
      idle(2);

      // Reset with an LDI on the outputs and 3 words still queued
      push_word(mk(3'd5, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000), 1'b0, '0);
      idle(3);
      for (int i = 0; i < 4; i++) begin
         push_word(mk(3'd1, 2'd0, 3'd0, 3'd0, 3'(i + 4), 16'h7000 + 16'(i)), 1'b1,
                   mko(0, 1, 0, 0, 0, 3'(i + 4), 16'h7000 + 16'(i)));
      end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      tick();
      check("prerst_out", 32'(cur()), 32'(mko(0, 1, 0, 0, 0, 4, 16'h7000)));
      reset = 1'b1;
      #1;
      exp_q.delete();
      check("midrst_out",   32'(cur()), 32'd0);
      check("midrst_busy",  32'(busy), 32'd0);
      check("midrst_ready", 32'(bus.instr_ready), 32'd1);
      tick();
      reset = 1'b0;
      idle(8);
      check("postrst_out",  32'(cur()), 32'd0);
      check("postrst_busy", 32'(busy), 32'd0);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
